// File: rtl/pokey_bus_sequencer.sv
// pokey_bus_sequencer
//   Round-robin arbiter and bus-cycle sequencer that lets two requesters
//   share one POKEY register interface on the system clock.
//
//   Parameters: SETUP_CYC (1..15), HIGH_CYC (2..15), LOW_CYC (1..15) set
//   the number of clocks in the setup, phi2-high and recovery phases.
//
//   Ports:
//     clk, clr                     system clock, synchronous active-high reset
//     reqN_valid/ready             request handshake (N = 0, 1)
//     reqN_we/addr/wdata           request payload (1 = write)
//     reqN_rdata/done              read data and one-cycle completion pulse
//     pokey_a/din/dout/rw/         POKEY A, Din, Dout, readHighWriteLow,
//     pokey_cs0_bar/phi2           cs0Bar and synthesized phi2
//     busy                         high whenever the sequencer is not idle
//
//   Optional feature: define POKEY_SEQ_SHADOW_EN to keep a shadow of the
//   write-only registers 0x0..0x7 and answer reads of them without a bus cycle.
module pokey_bus_sequencer #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HIGH_CYC  = 4,
  parameter int unsigned LOW_CYC   = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_we,
  input  logic [3:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic [7:0] req0_rdata,
  output logic       req0_done,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_we,
  input  logic [3:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic [7:0] req1_rdata,
  output logic       req1_done,
  output logic [3:0] pokey_a,
  output logic [7:0] pokey_din,
  input  logic [7:0] pokey_dout,
  output logic       pokey_rw,
  output logic       pokey_cs0_bar,
  output logic       pokey_phi2,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, RECOVER} state_t;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] HIGH_LD  = 4'(HIGH_CYC - 1);
  localparam logic [3:0] LOW_LD   = 4'(LOW_CYC - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;

  logic       we_r;
  logic [3:0] addr_r;
  logic [7:0] wdata_r;
  logic       win_r;
  logic       last_g;      // 1 = requester 1 was granted last

  logic       grant1;
  logic       accept;
  logic       shadow_rd;
  logic       acc_we;
  logic [3:0] acc_addr;
  logic [7:0] acc_wdata;

  // On a tie the requester not granted last wins.
  always_comb begin
    grant1     = req1_valid & (~req0_valid | ~last_g);
    accept     = (state == IDLE) & (req0_valid | req1_valid);
    req0_ready = (state == IDLE) & req0_valid & ~grant1;
    req1_ready = (state == IDLE) & grant1;
    acc_we     = grant1 ? req1_we    : req0_we;
    acc_addr   = grant1 ? req1_addr  : req0_addr;
    acc_wdata  = grant1 ? req1_wdata : req0_wdata;
`ifdef POKEY_SEQ_SHADOW_EN
    shadow_rd  = accept & ~acc_we & ~acc_addr[3];
`else
    shadow_rd  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    pokey_a       = '0;
    pokey_din     = '0;
    pokey_rw      = 1'b1;
    pokey_cs0_bar = 1'b1;
    pokey_phi2    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !shadow_rd) begin
          state_n = SETUP;
          cnt_n   = SETUP_LD;
        end
      end
      SETUP: begin
        pokey_a       = addr_r;
        pokey_din     = wdata_r;
        pokey_rw      = ~we_r;
        pokey_cs0_bar = 1'b0;
        if (cnt == 4'd0) begin
          state_n = HIGH;
          cnt_n   = HIGH_LD;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      HIGH: begin
        pokey_a       = addr_r;
        pokey_din     = wdata_r;
        pokey_rw      = ~we_r;
        pokey_cs0_bar = 1'b0;
        pokey_phi2    = 1'b1;
        if (cnt == 4'd0) begin
          state_n = RECOVER;
          cnt_n   = LOW_LD;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RECOVER: begin
        pokey_a   = addr_r;
        pokey_din = wdata_r;
        if (cnt == 4'd0) state_n = IDLE;
        else             cnt_n   = cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef POKEY_SEQ_SHADOW_EN
  logic [7:0] shadow [8];
`endif

  // Read data is written straight into the winner's rdata register on the
  // last HIGH cycle, so it appears together with done and then holds.
  always_ff @(posedge clk) begin
    if (clr) begin
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      win_r      <= 1'b0;
      last_g     <= 1'b1;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
`ifdef POKEY_SEQ_SHADOW_EN
      for (int unsigned i = 0; i < 8; i++) shadow[i] <= '0;
`endif
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      if (accept) begin
        we_r    <= acc_we;
        addr_r  <= acc_addr;
        wdata_r <= acc_wdata;
        win_r   <= grant1;
        last_g  <= grant1;
      end
`ifdef POKEY_SEQ_SHADOW_EN
      if (shadow_rd) begin
        if (grant1) begin
          req1_done  <= 1'b1;
          req1_rdata <= shadow[acc_addr[2:0]];
        end else begin
          req0_done  <= 1'b1;
          req0_rdata <= shadow[acc_addr[2:0]];
        end
      end
      if (accept && acc_we) begin
        if (!acc_addr[3]) shadow[acc_addr[2:0]] <= acc_wdata;
        else if (acc_addr == 4'hF && acc_wdata[1:0] == 2'b00)
          for (int unsigned i = 0; i < 8; i++) shadow[i] <= '0;
      end
`endif
      if (state == HIGH && cnt == 4'd0) begin
        if (win_r) begin
          req1_done <= 1'b1;
          if (!we_r) req1_rdata <= pokey_dout;
        end else begin
          req0_done <= 1'b1;
          if (!we_r) req0_rdata <= pokey_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_pokey_bus_sequencer.sv
// Testbench for pokey_bus_sequencer: default-parameter instance driven by
// directed and random requests, plus a SETUP=1/HIGH=2/LOW=1 corner instance.
module tb_pokey_bus_sequencer;

  localparam int S = 2, H = 4, L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clr = 1'b1;

  logic       r0v = 1'b0, r0w = 1'b0, r1v = 1'b0, r1w = 1'b0;
  logic [3:0] r0a = '0, r1a = '0;
  logic [7:0] r0d = '0, r1d = '0;
  logic       r0rdy, r1rdy, r0dn, r1dn;
  logic [7:0] r0rd, r1rd;
  logic [3:0] pa;
  logic [7:0] pdin, pdout;
  logic       prw, pcs, pphi, busy;

  logic       cv = 1'b0, cw = 1'b0, c1v = 1'b0, c1w = 1'b0;
  logic [3:0] ca = '0, c1a = '0;
  logic [7:0] cd = '0, c1d = '0;
  logic       crdy, cdn, c1rdy, c1dn;
  logic [7:0] crd, c1rd;
  logic [3:0] pa2;
  logic [7:0] pdin2, pdout2;
  logic       prw2, pcs2, pphi2, busy2;

  pokey_bus_sequencer #(.SETUP_CYC(S), .HIGH_CYC(H), .LOW_CYC(L)) dut (
    .clk(clk), .clr(clr),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_we(r0w), .req0_addr(r0a),
    .req0_wdata(r0d), .req0_rdata(r0rd), .req0_done(r0dn),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_we(r1w), .req1_addr(r1a),
    .req1_wdata(r1d), .req1_rdata(r1rd), .req1_done(r1dn),
    .pokey_a(pa), .pokey_din(pdin), .pokey_dout(pdout), .pokey_rw(prw),
    .pokey_cs0_bar(pcs), .pokey_phi2(pphi), .busy(busy));

  pokey_bus_sequencer #(.SETUP_CYC(1), .HIGH_CYC(2), .LOW_CYC(1)) dut2 (
    .clk(clk), .clr(clr),
    .req0_valid(cv), .req0_ready(crdy), .req0_we(cw), .req0_addr(ca),
    .req0_wdata(cd), .req0_rdata(crd), .req0_done(cdn),
    .req1_valid(c1v), .req1_ready(c1rdy), .req1_we(c1w), .req1_addr(c1a),
    .req1_wdata(c1d), .req1_rdata(c1rd), .req1_done(c1dn),
    .pokey_a(pa2), .pokey_din(pdin2), .pokey_dout(pdout2), .pokey_rw(prw2),
    .pokey_cs0_bar(pcs2), .pokey_phi2(pphi2), .busy(busy2));

  // POKEY model: readable registers in rdtab; Dout is only correct from the
  // second phi2-high cycle on (inverted garbage on the first).
  logic [7:0] rdtab [16];
  int hic = 0, hic2 = 0, cyc = 0;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    hic  <= pphi  ? hic + 1  : 0;
    hic2 <= pphi2 ? hic2 + 1 : 0;
  end
  assign pdout  = (hic  >= 1) ? rdtab[pa]  : ~rdtab[pa];
  assign pdout2 = (hic2 >= 1) ? rdtab[pa2] : ~rdtab[pa2];

  typedef struct {int port; logic [7:0] rdata; int due;} exp_t;
  exp_t q[$];

  int errors = 0, checks = 0;
  int acc_cnt [2] = '{0, 0};
  int c_acc = 0;

  // Reference model state (transaction timeline, not FSM state).
  logic       cur_v = 1'b0, cur_we = 1'b0;
  int         cur_t = 0, free_at = 0, last_g = 1;
  logic [3:0] cur_a = '0;
  logic [7:0] cur_d = '0;
  logic [7:0] exp_rd [2] = '{8'h00, 8'h00};
  logic [7:0] pend_rd [2] = '{8'h00, 8'h00};
  logic [7:0] sh_m [8] = '{default: 8'h00};
  logic       c_act = 1'b0;
  int         c_t = 0, c_free = 0;
  logic [3:0] c_a = '0;
  logic [7:0] c_exp = '0, c_pend = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, expv);
    end
  endtask

  // Monitor/scoreboard: compares every cycle against the model timeline.
  int m_k, m_win;
  logic m_free, m_any, m_busy, m_rw, m_cs, m_phi;
  logic [3:0] m_a;
  logic [7:0] m_d;
  logic [1:0] m_dn;
  exp_t e;
  always @(negedge clk) if (cyc >= 1) begin
    m_busy = 0; m_a = '0; m_d = '0; m_rw = 1; m_cs = 1; m_phi = 0;
    if (cur_v) begin
      m_k = cyc - cur_t;
      if (m_k >= 1 && m_k <= S + H + L) begin
        m_busy = 1; m_a = cur_a; m_d = cur_d;
        if (m_k <= S + H) begin
          m_cs = 0; m_rw = ~cur_we; m_phi = (m_k > S);
        end
      end
    end
    chk("bus", 32'({busy, pa, pdin, prw, pcs, pphi}), 32'({m_busy, m_a, m_d, m_rw, m_cs, m_phi}));
    m_dn = 2'b00;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      m_dn = (e.port == 1) ? 2'b10 : 2'b01;
      exp_rd[e.port] = e.rdata;
    end
    chk("done", 32'({r1dn, r0dn}), 32'(m_dn));
    chk("rdata", 32'({r1rd, r0rd}), 32'({exp_rd[1], exp_rd[0]}));
    m_free = (cyc >= free_at);
    m_any  = r0v | r1v;
    m_win  = (r0v && r1v) ? ((last_g == 1) ? 0 : 1) : (r1v ? 1 : 0);
    chk("ready", 32'({r1rdy, r0rdy}), 32'({m_free && m_any && m_win == 1, m_free && m_any && m_win == 0}));
    if (clr) begin
      q.delete(); cur_v = 0; last_g = 1; free_at = cyc + 1;
      exp_rd = '{8'h00, 8'h00}; pend_rd = '{8'h00, 8'h00};
      for (int i = 0; i < 8; i++) sh_m[i] = 8'h00;
    end else if (m_free && m_any) begin
      e.port = m_win;
      acc_cnt[m_win]++;
      last_g = m_win;
      cur_we = m_win ? r1w : r0w;
      cur_a  = m_win ? r1a : r0a;
      cur_d  = m_win ? r1d : r0d;
      cur_t  = cyc;
`ifdef POKEY_SEQ_SHADOW_EN
      if (!cur_we && cur_a < 4'd8) begin
        cur_v = 0; e.due = cyc + 1; free_at = cyc + 1;
        pend_rd[m_win] = sh_m[cur_a[2:0]];
      end else
`endif
      begin
        cur_v = 1; e.due = cyc + S + H + 1; free_at = cyc + S + H + L + 1;
        if (!cur_we) pend_rd[m_win] = rdtab[cur_a];
      end
      e.rdata = pend_rd[m_win];
      q.push_back(e);
`ifdef POKEY_SEQ_SHADOW_EN
      if (cur_we && cur_a < 4'd8) sh_m[cur_a[2:0]] = cur_d;
      else if (cur_we && cur_a == 4'hF && cur_d[1:0] == 2'b00)
        for (int i = 0; i < 8; i++) sh_m[i] = 8'h00;
`endif
    end
    // Corner instance: 1 setup + 2 high + 1 recover, reads only.
    m_busy = 0; m_cs = 1; m_phi = 0; m_a = '0; m_k = 0;
    if (c_act) begin
      m_k = cyc - c_t;
      if (m_k >= 1 && m_k <= 4) begin
        m_busy = 1; m_a = c_a; m_cs = (m_k == 4); m_phi = (m_k == 2 || m_k == 3);
      end
    end
    if (m_k == 4) c_exp = c_pend;
    chk("c_bus", 32'({busy2, pcs2, pphi2, prw2, pa2}), 32'({m_busy, m_cs, m_phi, 1'b1, m_a}));
    chk("c_done", 32'(cdn), 32'(m_k == 4));
    chk("c_rdata", 32'(crd), 32'(c_exp));
    chk("c_ready", 32'(crdy), 32'(cv && cyc >= c_free));
    if (clr) begin
      c_act = 0; c_exp = '0; c_free = cyc + 1;
    end else if (cv && cyc >= c_free) begin
      c_act = 1; c_t = cyc; c_free = cyc + 5; c_a = ca; c_pend = rdtab[ca]; c_acc++;
    end
  end

  task automatic issue(input int p, input logic we, input logic [3:0] a, input logic [7:0] d);
    int start;
    bit got;
    @(posedge clk); #1;
    if (p == 0) begin r0v = 1; r0w = we; r0a = a; r0d = d; end
    else        begin r1v = 1; r1w = we; r1a = a; r1d = d; end
    start = acc_cnt[p];
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (acc_cnt[p] != start) got = 1;
    end
    if (!got) begin
      $display("FAIL accept_timeout port %0d: got no accept expected accept within 300 cycles", p);
      $fatal(1);
    end
    @(posedge clk); #1;
    if (p == 0) r0v = 0; else r1v = 0;
  endtask

  task automatic cissue(input logic [3:0] a);
    int start;
    bit got;
    @(posedge clk); #1;
    cv = 1; ca = a;
    start = c_acc;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (c_acc != start) got = 1;
    end
    if (!got) begin
      $display("FAIL c_accept_timeout: got no accept expected accept within 50 cycles");
      $fatal(1);
    end
    @(posedge clk); #1;
    cv = 0;
  endtask

  function automatic logic [3:0] rnd_addr();
    logic [3:0] a;
    a = 4'($urandom);
    if ($urandom_range(0, 3) == 0) a = 4'hF;
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) rdtab[i] = 8'($urandom);
    rdtab[10] = 8'h3C;
    repeat (3) @(posedge clk);
    #1 clr = 0;
    // Single write, then a read from requester 1.
    issue(0, 1'b1, 4'h1, 8'hA5);
    issue(1, 1'b0, 4'hA, 8'h00);
    // Contention: both requesters continuously valid.
    fork
      repeat (2) issue(0, 1'b1, 4'h2, 8'h11);
      repeat (2) issue(1, 1'b0, 4'h9, 8'h00);
    join
    // Shadow sequence (full bus reads when the shadow is not built in).
    issue(0, 1'b1, 4'h4, 8'h77);
    issue(1, 1'b0, 4'h4, 8'h00);
    issue(0, 1'b1, 4'hF, 8'h00);
    issue(1, 1'b0, 4'h4, 8'h00);
    // Reset during the first HIGH cycle, then a tie.
    issue(0, 1'b0, 4'h9, 8'h00);
    repeat (2) @(posedge clk);
    #1 clr = 1;
    @(posedge clk);
    #1 clr = 0;
    fork
      issue(0, 1'b1, 4'h3, 8'h5A);
      issue(1, 1'b1, 4'h5, 8'hC3);
    join
    // Random traffic.
    repeat (30) begin
      fork
        begin
          if ($urandom_range(0, 3) != 0) begin
            repeat ($urandom_range(0, 10)) @(posedge clk);
            issue(0, 1'($urandom), rnd_addr(), 8'($urandom));
          end
        end
        begin
          if ($urandom_range(0, 3) != 0) begin
            repeat ($urandom_range(0, 10)) @(posedge clk);
            issue(1, 1'($urandom), rnd_addr(), 8'($urandom));
          end
        end
      join
    end
    // Parameter corner instance.
    cissue(4'hA);
    cissue(4'($urandom));
    cissue(4'($urandom));
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pokey_bus_sequencer.md
# pokey_bus_sequencer

Two-port arbiter and bus-cycle sequencer that shares one POKEY register interface between two requesters, for example the host CPU and a sound-effect sequencer. It accepts single register read/write requests on valid/ready handshakes, picks a winner round-robin, and generates the POKEY bus cycle on the fast system clock: `A`, `Din`, `readHighWriteLow`, `cs0Bar`, and a synthesized `phi2` strobe. It returns read data and a completion pulse to the winning requester.

## Interface
Parameters:
- `SETUP_CYC`, 2: cycles address/data/cs are driven with `phi2` low before the strobe. Legal range 1..15.
- `HIGH_CYC`, 4: cycles `phi2` is held high. Legal range 2..15.
- `LOW_CYC`, 2: recovery cycles with `phi2` low and `cs0_bar` high after the strobe. Legal range 1..15.

Ports (direction, width, meaning):
- `clk` in 1: system clock; the same clock that runs the POKEY.
- `clr` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 holds a request.
- `req0_ready` out 1: request accepted this cycle when high together with `req0_valid`.
- `req0_we` in 1: 1 = write, 0 = read.
- `req0_addr` in 4: POKEY register address.
- `req0_wdata` in 8: write data.
- `req0_rdata` out 8: read data; valid while `req0_done` is high.
- `req0_done` out 1: one-cycle completion pulse for reads and writes.
- `req1_*`: identical set for requester 1.
- `pokey_a` out 4: to POKEY `A`.
- `pokey_din` out 8: to POKEY `Din`.
- `pokey_dout` in 8: from POKEY `Dout`.
- `pokey_rw` out 1: to POKEY `readHighWriteLow`.
- `pokey_cs0_bar` out 1: to POKEY `cs0Bar`.
- `pokey_phi2` out 1: to POKEY `phi2`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- State machine has four states: IDLE, SETUP, HIGH, RECOVER. A 4-bit down counter `cnt` times each phase.
- **IDLE**
  - `ready` is high only for the arbitration winner, and only while it is valid.
  - On accept, latch `we`, `addr`, `wdata` and the winner id, load `cnt` = `SETUP_CYC-1`, then go to SETUP.
- **Arbitration**
  - A single valid requester wins.
  - When both are valid, the requester not granted last wins.
  - The last-grant pointer resets to "requester 1", so requester 0 wins the first tie.
- **SETUP**
  - Drive `pokey_a` = addr, `pokey_din` = wdata, `pokey_rw` = ~we, `pokey_cs0_bar` = 0, `pokey_phi2` = 0.
  - When `cnt` reaches 0, go to HIGH with `cnt` = `HIGH_CYC-1`.
- **HIGH**
  - Same bus drive as SETUP, with `pokey_phi2` = 1. The POKEY detects the rising edge on the first HIGH cycle.
  - For reads, capture `pokey_dout` into the read register on the last HIGH cycle. POKEY `Dout` is valid from the second HIGH cycle onward, which is why `HIGH_CYC` must be at least 2.
  - At `cnt` = 0, go to RECOVER with `cnt` = `LOW_CYC-1`.
- **RECOVER**
  - `pokey_cs0_bar` = 1, `pokey_phi2` = 0, `pokey_rw` = 1. `pokey_a` and `pokey_din` hold their values.
  - On the first RECOVER cycle, pulse the winner's `done`. For reads, drive the captured data on the winner's `rdata`.
  - At `cnt` = 0, go to IDLE.
- **Outputs in IDLE:** `pokey_a` = 0, `pokey_din` = 0, `pokey_rw` = 1, `pokey_cs0_bar` = 1, `pokey_phi2` = 0.
- `rdata` holds its last value between transactions. Its reset value is 0.

## Timing
- Reset values: state IDLE, all `ready`/`done` = 0, `rdata` = 0, `busy` = 0, POKEY outputs at their IDLE values, shadow registers = 0.
- Bus cycle length is `SETUP_CYC` + `HIGH_CYC` + `LOW_CYC` cycles, which is 8 with the defaults.
- `done` fires `SETUP_CYC` + `HIGH_CYC` + 1 cycles after the accept cycle.
- The next accept can occur in the first IDLE cycle. Back-to-back throughput is one transaction per (bus cycle + 1) cycles.
- `ready` is combinational from state and valid. Requesters must hold valid and payload stable until accepted.
- `clr` asserted mid-cycle forces the IDLE outputs on the next edge. The in-flight transaction is dropped with no `done`, and the grant pointer is reset.

## Configuration
- `POKEY_SEQ_SHADOW_EN` defined:
  - An 8-entry shadow of the write-only registers 0x0–0x7 (AUDF1..AUDC4) is updated on accept of any write to those addresses.
  - Reads of 0x0–0x7 run no bus cycle: the sequencer stays in IDLE and the winner gets `done` with `rdata` = shadow on the next cycle.
  - An accepted write to 0xF with `wdata[1:0]` == 00 clears all shadow entries, mirroring the POKEY's internal clear.
- `POKEY_SEQ_SHADOW_EN` undefined:
  - No shadow storage exists.
  - Every read performs a full bus cycle, and the returned data is whatever `pokey_dout` presents.

## Test plan
- **Single write:** req0 write addr 0x1 data 0xA5 with defaults. Require `pokey_cs0_bar` low for 6 cycles with `pokey_a` = 1, `pokey_din` = 0xA5, `pokey_rw` = 0; `phi2` high for cycles 3–6; `req0_done` pulse at accept+7; `busy` low at accept+9.
- **Read:** req1 read 0xA with the POKEY model returning 0x3C. Require `req1_rdata` = 0x3C with `req1_done`, and `req0_done` stays 0.
- **Contention:** both valid continuously, 4 transactions. Require grant order 0,1,0,1 and no accept while `busy`.
- **Reset mid-cycle:** assert `clr` during HIGH. Require IDLE outputs next cycle, no `done`, and the first tie afterwards granted to req0.
- **Shadow (`POKEY_SEQ_SHADOW_EN`):**
  - Write 0x4 ← 0x77, then read 0x4. Require `done` one cycle after accept with `rdata` = 0x77 and no `cs0_bar` activity.
  - Write 0xF ← 0x00, then read 0x4. Require `rdata` = 0x00.
- **Parameter corner:** `SETUP_CYC`=1, `HIGH_CYC`=2, `LOW_CYC`=1. Require a 4-cycle bus cycle and correct read capture on the second HIGH cycle.
